// File: rtl/sat_chan_gen.sv
// sat_chan_gen: single-SV signal generator (Doppler NCO, sin/cos LUT, chip modulation, complex mult, saturating gain)
// Ports: clk, reset (sync, active-high); enable advances the NCO and marks the sample valid;
//   cfg_valid/cfg_ready/cfg_freq/cfg_gain/cfg_sel stage one config that goes live on ca_epoch;
//   ca_seq/pcode_seq hold the chips of all SVs, indexed by the active sel;
//   real_out/imag_out/out_valid follow the sample that enable marked, four clocks later.
// Define SAT_CHAN_PCODE_EN to drive the in-phase arm with the P code (otherwise it is zero).
module sat_chan_gen #(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 8,
    parameter int AMP_W    = 9,
    parameter int P_AMP    = 180,
    parameter int GAIN_W   = 16,
    parameter int OUT_W    = 16,
    parameter int CA_CHANS = 36,
    parameter int SEL_W    = $clog2(CA_CHANS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PHASE_W-1:0]  cfg_freq,
    input  logic [GAIN_W-1:0]   cfg_gain,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic                ca_epoch,
    input  logic [CA_CHANS-1:0] ca_seq,
    input  logic [CA_CHANS-1:0] pcode_seq,
    output logic [OUT_W-1:0]    real_out,
    output logic [OUT_W-1:0]    imag_out,
    output logic                out_valid
);
    localparam int A  = 2 ** (AMP_W - 1) - 1;
    localparam int N  = 2 ** LUT_AW;
    localparam int PW = 2 * AMP_W + 1;
    localparam int MW = PW + GAIN_W + 1;
    localparam int SH = 2 * AMP_W + GAIN_W - OUT_W - 1;
    localparam real TWO_PI = 6.283185307179586;
    localparam logic signed [AMP_W-1:0] POS_A = AMP_W'(A);
    localparam logic signed [AMP_W-1:0] NEG_A = -POS_A;
    localparam logic signed [AMP_W-1:0] POS_P = AMP_W'(P_AMP);
    localparam logic signed [AMP_W-1:0] NEG_P = -POS_P;
    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic {EMPTY, PENDING} cfg_st_t;

    // Quarter points are forced so the axes carry exact zeros and full-scale values.
    function automatic logic signed [AMP_W-1:0] lut_val(input int k, input logic is_sin);
        real x;
        int r;
        int q;
        x = real'(A) * (is_sin ? $sin(TWO_PI * k / N) : $cos(TWO_PI * k / N));
        r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        q = (k / (N / 4) + (is_sin ? 3 : 0)) % 4;
        if (k % (N / 4) == 0)
            r = (q == 0) ? A : (q == 2) ? -A : 0;
        return AMP_W'(r);
    endfunction

    // Gain is treated as unsigned; the floor shift keeps negative results rounding toward -inf.
    function automatic logic signed [OUT_W-1:0] scale(input logic signed [PW-1:0] p, input logic [GAIN_W-1:0] g);
        logic signed [MW-1:0] m;
        m = (MW'(p) * $signed(MW'({1'b0, g}))) >>> SH;
        return (m > MW'(OMAX)) ? OMAX : (m < MW'(OMIN)) ? OMIN : m[OUT_W-1:0];
    endfunction

    logic signed [AMP_W-1:0] cos_lut [N];
    logic signed [AMP_W-1:0] sin_lut [N];
    for (genvar k = 0; k < N; k++) begin : g_lut
        assign cos_lut[k] = lut_val(k, 1'b0);
        assign sin_lut[k] = lut_val(k, 1'b1);
    end

    cfg_st_t st, st_nx;
    logic [PHASE_W-1:0] phase, act_freq, sh_freq;
    logic [GAIN_W-1:0] act_gain, sh_gain, s1_gain, s2_gain, s3_gain;
    logic [SEL_W-1:0] act_sel, sh_sel;
    logic [LUT_AW-1:0] s1_idx;
    logic signed [AMP_W-1:0] re_d, im_d, s1_re, s1_im, s2_re, s2_im, s2_cos, s2_sin;
    logic signed [PW-1:0] m_re, m_im, s3_re, s3_im;
    logic s1_v, s2_v, s3_v, sel_ok, epoch_apply;

    always_ff @(posedge clk)
        st <= reset ? EMPTY : st_nx;

    always_comb
        st_nx = (st == EMPTY) ? (cfg_valid ? PENDING : EMPTY) : (ca_epoch ? EMPTY : PENDING);

    always_comb
        cfg_ready = (st == EMPTY);

    assign epoch_apply = (st == PENDING) && ca_epoch;
    assign sel_ok = int'(act_sel) < CA_CHANS;
    assign im_d = !sel_ok ? '0 : ca_seq[act_sel] ? NEG_A : POS_A;
`ifdef SAT_CHAN_PCODE_EN
    assign re_d = !sel_ok ? '0 : pcode_seq[act_sel] ? NEG_P : POS_P;
`else
    logic unused_pcode;
    assign unused_pcode = ^{pcode_seq, POS_P, NEG_P};
    assign re_d = '0;
`endif

    assign m_re = PW'(s2_re) * PW'(s2_cos) - PW'(s2_im) * PW'(s2_sin);
    assign m_im = PW'(s2_re) * PW'(s2_sin) + PW'(s2_im) * PW'(s2_cos);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            act_freq  <= '0;
            act_gain  <= '0;
            act_sel   <= '0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            out_valid <= 1'b0;
            real_out  <= '0;
            imag_out  <= '0;
        end else begin
            if (enable)
                phase <= phase + act_freq;
            if (epoch_apply)
                {act_freq, act_gain, act_sel} <= {sh_freq, sh_gain, sh_sel};
            s1_v      <= enable;
            s2_v      <= s1_v;
            s3_v      <= s2_v;
            out_valid <= s3_v;
            real_out  <= s3_v ? scale(s3_re, s3_gain) : '0;
            imag_out  <= s3_v ? scale(s3_im, s3_gain) : '0;
        end
    end

    // Data stages carry gain alongside each sample so an epoch never mixes old and new settings.
    always_ff @(posedge clk) begin
        if (cfg_valid && cfg_ready)
            {sh_freq, sh_gain, sh_sel} <= {cfg_freq, cfg_gain, cfg_sel};
        s1_idx  <= phase[PHASE_W-1 -: LUT_AW];
        s1_re   <= re_d;
        s1_im   <= im_d;
        s1_gain <= act_gain;
        s2_cos  <= cos_lut[s1_idx];
        s2_sin  <= sin_lut[s1_idx];
        s2_re   <= s1_re;
        s2_im   <= s1_im;
        s2_gain <= s1_gain;
        s3_re   <= m_re;
        s3_im   <= m_im;
        s3_gain <= s2_gain;
    end
endmodule

// File: tb/tb_sat_chan_gen.sv
// tb_sat_chan_gen: self-checking bench for sat_chan_gen (directed tables, handshake sequences, random vs model)
module tb_sat_chan_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, enable = 1'b0, cfg_valid = 1'b0, ca_epoch = 1'b0;
    logic cfg_ready, out_valid;
    logic [31:0] cfg_freq = '0;
    logic [15:0] cfg_gain = '0;
    logic [5:0] cfg_sel = '0;
    logic [35:0] ca_seq = '0, pcode_seq = '0;
    logic signed [15:0] real_out, imag_out;
    int total = 0, bad = 0;

    sat_chan_gen dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_gain(cfg_gain), .cfg_sel(cfg_sel), .ca_epoch(ca_epoch),
        .ca_seq(ca_seq), .pcode_seq(pcode_seq), .real_out(real_out), .imag_out(imag_out),
        .out_valid(out_valid)
    );

    typedef struct {bit v; int re; int im;} samp_t;
    typedef struct {logic [15:0] gain; logic [5:0] sel; logic ca; int exp_re; int exp_im;} vec_t;

    samp_t pipe [4];
    bit [31:0] m_phase, a_freq, s_freq;
    bit [15:0] a_gain, s_gain;
    bit [5:0] a_sel, s_sel;
    bit pend;

    function automatic int rnd(real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int clamp(longint x);
        return x > 32767 ? 32767 : x < -32768 ? -32768 : int'(x);
    endfunction

    // Expected output of the sample taken now, from the signal definition itself.
    function automatic samp_t sample();
        samp_t s;
        real ang;
        int c, sn, cd, pd, re, im;
        ang = 2.0 * 3.141592653589793 * real'(int'(m_phase[31:24])) / 256.0;
        c = rnd(255.0 * $cos(ang));
        sn = rnd(255.0 * $sin(ang));
        cd = 0;
        pd = 0;
        if (a_sel < 36) begin
            cd = ca_seq[a_sel] ? -255 : 255;
`ifdef SAT_CHAN_PCODE_EN
            pd = pcode_seq[a_sel] ? -180 : 180;
`endif
        end
        re = pd * c - cd * sn;
        im = pd * sn + cd * c;
        s.v = enable;
        s.re = enable ? clamp((longint'(re) * longint'(a_gain)) >>> 17) : 0;
        s.im = enable ? clamp((longint'(im) * longint'(a_gain)) >>> 17) : 0;
        return s;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_phase = '0;
            a_freq = '0;
            a_gain = '0;
            a_sel = '0;
            pend = 1'b0;
            foreach (pipe[i]) pipe[i] = '{v: 1'b0, re: 0, im: 0};
        end else begin
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = sample();
            if (enable) m_phase += a_freq;
            if (pend && ca_epoch) begin
                a_freq = s_freq;
                a_gain = s_gain;
                a_sel = s_sel;
                pend = 1'b0;
            end else if (!pend && cfg_valid) begin
                s_freq = cfg_freq;
                s_gain = cfg_gain;
                s_sel = cfg_sel;
                pend = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid", out_valid, pipe[3].v);
        chk("model_real", real_out, pipe[3].re);
        chk("model_imag", imag_out, pipe[3].im);
        chk("model_ready", cfg_ready, !pend);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, out_valid, 1);
    endtask

    task automatic do_cfg(input logic [31:0] f, input logic [15:0] g, input logic [5:0] s);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_freq = f;
        cfg_gain = g;
        cfg_sel = s;
        tick();
        cfg_valid = 1'b0;
        ca_epoch = 1'b1;
        tick();
        ca_epoch = 1'b0;
    endtask

    initial begin
        vec_t vecs [8];
        int t3_re [4];
        int t3_im [4];
        vecs[0] = '{16'h8000, 6'd3, 1'b0, 0, 16256};
        vecs[1] = '{16'h8000, 6'd3, 1'b1, 0, -16257};
        vecs[2] = '{16'hFFFF, 6'd3, 1'b0, 0, 32512};
        vecs[3] = '{16'hFFFF, 6'd3, 1'b1, 0, -32513};
        vecs[4] = '{16'h0001, 6'd7, 1'b0, 0, 0};
        vecs[5] = '{16'h0001, 6'd7, 1'b1, 0, -1};
        vecs[6] = '{16'h8000, 6'd40, 1'b1, 0, 0};
        vecs[7] = '{16'h0000, 6'd35, 1'b1, 0, 0};
`ifdef SAT_CHAN_PCODE_EN
        t3_re = '{11475, -16257, -11475, 16256};
        t3_im = '{16256, 11475, -16257, -11475};
`else
        t3_re = '{0, -16257, 0, 16256};
        t3_im = '{16256, 0, -16257, 0};
`endif

        // reset, enable with no config: silent but valid after four clocks
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("t1_valid_early", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_real", real_out, 0);
        chk("t1_imag", imag_out, 0);
        chk("t1_ready", cfg_ready, 1);

        // zero-Doppler table: phase stays at 0, so output is the scaled chip
        for (int i = 0; i < 8; i++) begin
            ca_seq = vecs[i].ca ? '1 : '0;
            pcode_seq = '0;
            do_cfg(32'h0, vecs[i].gain, vecs[i].sel);
            for (int j = 0; j < 5; j++) tick();
`ifndef SAT_CHAN_PCODE_EN
            chk($sformatf("vec%0d_real", i), real_out, vecs[i].exp_re);
`endif
            chk($sformatf("vec%0d_imag", i), imag_out, vecs[i].exp_im);
        end

        // quarter-turn Doppler rotates through the four axes
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        ca_seq = '0;
        pcode_seq = '0;
        do_cfg(32'h4000_0000, 16'h8000, 6'd3);
        enable = 1'b1;
        wait_valid("t3_wait_valid");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_real%0d", i), real_out, t3_re[i % 4]);
            chk($sformatf("t3_imag%0d", i), imag_out, t3_im[i % 4]);
            tick();
        end

        // handshake: second offer held while pending, taken the cycle after the epoch
        for (int n = 0; n < 50 && !cfg_ready; n++) tick();
        cfg_valid = 1'b1;
        cfg_freq = 32'h0100_0000;
        cfg_gain = 16'h4000;
        cfg_sel = 6'd5;
        tick();
        chk("t4_ready_accept", cfg_ready, 0);
        cfg_freq = 32'h0200_0000;
        cfg_gain = 16'hFFFF;
        cfg_sel = 6'd6;
        tick();
        chk("t4_ready_held", cfg_ready, 0);
        ca_epoch = 1'b1;
        tick();
        ca_epoch = 1'b0;
        chk("t4_ready_epoch", cfg_ready, 1);
        tick();
        chk("t4_second_taken", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick();
        ca_epoch = 1'b1;
        tick();
        ca_epoch = 1'b0;
        chk("t4_ready_end", cfg_ready, 1);
        for (int i = 0; i < 6; i++) tick();

        // 45-degree point with full gain
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        ca_seq = '0;
        pcode_seq = '0;
        do_cfg(32'h2000_0000, 16'hFFFF, 6'd3);
        enable = 1'b1;
        wait_valid("t5_wait_valid");
        tick();
`ifdef SAT_CHAN_PCODE_EN
        chk("t5_real", real_out, -6750);
        chk("t5_imag", imag_out, 32767);
`else
        chk("t5_real", real_out, -22950);
        chk("t5_imag", imag_out, 22949);
`endif

        // reset with a config pending: drops it, outputs clear next clock
        cfg_valid = 1'b1;
        cfg_freq = 32'h0;
        cfg_gain = 16'h7FFF;
        cfg_sel = 6'd3;
        tick();
        cfg_valid = 1'b0;
        chk("t6_pending", cfg_ready, 0);
        reset = 1'b1;
        tick();
        chk("t6_valid", out_valid, 0);
        chk("t6_real", real_out, 0);
        chk("t6_imag", imag_out, 0);
        chk("t6_ready", cfg_ready, 1);
        reset = 1'b0;
        ca_epoch = 1'b1;
        tick();
        ca_epoch = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_after_valid", out_valid, 1);
        chk("t6_after_imag", imag_out, 0);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_freq = $urandom;
            cfg_gain = 16'($urandom);
            cfg_sel = 6'($urandom_range(0, 39));
            ca_epoch = ($urandom_range(0, 9) == 0);
            ca_seq = 36'({$urandom, $urandom});
            pcode_seq = 36'({$urandom, $urandom});
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
